// File: rtl/alarm_setter_if.sv
// Button inputs and alarm-setting outputs of the alarm setter, grouped as one bundle.
// The slave side is the alarm setter; the master side drives the raw buttons.
interface alarm_setter_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] alarm_mode;
    logic [5:0] alarm_sec;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       alarm_en;

    modport master (
        output btn_mode, btn_up, btn_down,
        input  alarm_mode, alarm_sec, alarm_min, alarm_hour, alarm_en
    );

    modport slave (
        input  btn_mode, btn_up, btn_down,
        output alarm_mode, alarm_sec, alarm_min, alarm_hour, alarm_en
    );
endinterface

// File: rtl/alarm_setter.sv
// Three-button alarm time setter on a 1 ms clock: synchronise, debounce, press/auto-repeat
// pulses, then a mode FSM that edits sec/min/hour or toggles the alarm enable.
module alarm_setter #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int TIMEOUT_MS      = 10000
) (
    input logic           msecclk,
    input logic           rst,
    alarm_setter_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int RW = $clog2(REPEAT_DELAY_MS + 1);
    localparam int TW = $clog2(TIMEOUT_MS + 1);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3
    } mode_t;

    // Button index: 0 mode, 1 up, 2 down.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db;
    logic [2:0]    db_q;
    logic [2:0]    press;
    logic [DW-1:0] dcnt [3];
    logic [RW-1:0] rcnt [2];
    logic [1:0]    rpt;

    assign raw   = {bus.btn_down, bus.btn_up, bus.btn_mode};
    assign press = db & ~db_q;

    always_ff @(posedge msecclk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                    dcnt[i] <= '0;
                    db[i]   <= sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // rcnt counts cycles since the press pulse; after each repeat it is rewound so the
    // next repeat lands exactly REPEAT_RATE_MS later.
    always_comb begin
        rpt = '0;
        for (int i = 0; i < 2; i++) rpt[i] = db[i+1] && (rcnt[i] == RW'(REPEAT_DELAY_MS));
    end

    always_ff @(posedge msecclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!db[i+1])    rcnt[i] <= '0;
                else if (rpt[i]) rcnt[i] <= RW'(REPEAT_DELAY_MS - REPEAT_RATE_MS + 1);
                else             rcnt[i] <= rcnt[i] + 1'b1;
            end
        end
    end

    logic ev_mode;
    logic ev_up;
    logic ev_down;
    logic ev_any;

    assign ev_mode = press[0];
    assign ev_up   = press[1] | rpt[0];
    assign ev_down = press[2] | rpt[1];
    assign ev_any  = ev_mode | ev_up | ev_down;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        if (up) return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    mode_t         state;
    mode_t         state_n;
    logic [5:0]    sec;
    logic [5:0]    sec_n;
    logic [5:0]    min;
    logic [5:0]    min_n;
    logic [4:0]    hour;
    logic [4:0]    hour_n;
    logic          en;
    logic          en_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;

    always_comb begin
        state_n = state;
        sec_n   = sec;
        min_n   = min;
        hour_n  = hour;
        en_n    = en;
        if (state == NORMAL || ev_any) tcnt_n = '0;
        else                           tcnt_n = tcnt + 1'b1;

        // Mode beats up/down; up together with down cancels out but still counts as activity.
        if (ev_mode) begin
            case (state)
                NORMAL: begin
                    state_n = SET_SEC;
                    en_n    = 1'b1;
                end
                SET_SEC: state_n = SET_MIN;
                SET_MIN: state_n = SET_HOUR;
                default: state_n = NORMAL;
            endcase
        end else if (ev_up ^ ev_down) begin
            case (state)
                NORMAL:   en_n   = ~en;
                SET_SEC:  sec_n  = wrap_step(sec, 6'd59, ev_up);
                SET_MIN:  min_n  = wrap_step(min, 6'd59, ev_up);
                SET_HOUR: hour_n = 5'(wrap_step({1'b0, hour}, 6'd23, ev_up));
                default:  state_n = NORMAL;
            endcase
        end else if (!ev_any && state != NORMAL && tcnt == TW'(TIMEOUT_MS - 1)) begin
            state_n = NORMAL;
        end
    end

    always_ff @(posedge msecclk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
            en    <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            sec   <= sec_n;
            min   <= min_n;
            hour  <= hour_n;
            en    <= en_n;
            tcnt  <= tcnt_n;
        end
    end

    assign bus.alarm_mode = state;
    assign bus.alarm_sec  = sec;
    assign bus.alarm_min  = min;
    assign bus.alarm_hour = hour;
    assign bus.alarm_en   = en;
endmodule

// File: tb/tb_alarm_setter.sv
// Bench for alarm_setter: fixed press table, multi-cycle corner sequences, and random
// presses checked against an arithmetic model of the alarm fields.
module tb_alarm_setter;
    logic msecclk;
    logic rst;
    alarm_setter_if bus();

    alarm_setter dut (
        .msecclk(msecclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial msecclk = 1'b0;
    always #5 msecclk = ~msecclk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] btns;   // bit0 mode, bit1 up, bit2 down
        int         hold;
        logic [2:0] mode;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       en;
    } vec_t;

    vec_t vecs [16];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int mode, input int sec, input int min,
                             input int hour, input int en);
        check({tag, ".mode"}, 32'(bus.alarm_mode), mode);
        check({tag, ".sec"},  32'(bus.alarm_sec),  sec);
        check({tag, ".min"},  32'(bus.alarm_min),  min);
        check({tag, ".hour"}, 32'(bus.alarm_hour), hour);
        check({tag, ".en"},   32'(bus.alarm_en),   en);
    endtask

    task automatic set_btns(input logic [2:0] b);
        bus.btn_mode = b[0];
        bus.btn_up   = b[1];
        bus.btn_down = b[2];
    endtask

    // Called at a negedge: hold for 'hold' cycles, release, let the release debounce settle.
    task automatic press(input logic [2:0] btns, input int hold);
        set_btns(btns);
        repeat (hold) @(negedge msecclk);
        set_btns(3'b000);
        repeat (40) @(negedge msecclk);
    endtask

    task automatic wait_normal(input string name, input int expected);
        int n;
        n = 0;
        while (bus.alarm_mode != 3'd0 && n < 12000) begin
            @(negedge msecclk);
            n++;
        end
        check(name, n, expected);
    endtask

    // Reference model: plain modular arithmetic on the alarm fields.
    int m_mode, m_sec, m_min, m_hour, m_en;

    task automatic model_pulse(input int b);
        int d;
        if (b == 0) begin
            if (m_mode == 0) m_en = 1;
            m_mode = (m_mode + 1) % 4;
        end else begin
            d = (b == 1) ? 1 : -1;
            case (m_mode)
                0: m_en = 1 - m_en;
                1: m_sec  = (m_sec + 60 + d) % 60;
                2: m_min  = (m_min + 60 + d) % 60;
                default: m_hour = (m_hour + 24 + d) % 24;
            endcase
        end
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t;
        int n;
        int b;
        int h;
        int npulse;
        logic [5:0] prev;

        vecs[0]  = '{3'b010, 30,  3'd0, 6'd0,  6'd0,  5'd0,  1'b1};
        vecs[1]  = '{3'b100, 30,  3'd0, 6'd0,  6'd0,  5'd0,  1'b0};
        vecs[2]  = '{3'b001, 30,  3'd1, 6'd0,  6'd0,  5'd0,  1'b1};
        vecs[3]  = '{3'b010, 30,  3'd1, 6'd1,  6'd0,  5'd0,  1'b1};
        vecs[4]  = '{3'b100, 30,  3'd1, 6'd0,  6'd0,  5'd0,  1'b1};
        vecs[5]  = '{3'b100, 30,  3'd1, 6'd59, 6'd0,  5'd0,  1'b1};
        vecs[6]  = '{3'b010, 30,  3'd1, 6'd0,  6'd0,  5'd0,  1'b1};
        vecs[7]  = '{3'b010, 650, 3'd1, 6'd3,  6'd0,  5'd0,  1'b1};
        vecs[8]  = '{3'b001, 30,  3'd2, 6'd3,  6'd0,  5'd0,  1'b1};
        vecs[9]  = '{3'b100, 30,  3'd2, 6'd3,  6'd59, 5'd0,  1'b1};
        vecs[10] = '{3'b001, 30,  3'd3, 6'd3,  6'd59, 5'd0,  1'b1};
        vecs[11] = '{3'b100, 30,  3'd3, 6'd3,  6'd59, 5'd23, 1'b1};
        vecs[12] = '{3'b010, 30,  3'd3, 6'd3,  6'd59, 5'd0,  1'b1};
        vecs[13] = '{3'b010, 550, 3'd3, 6'd3,  6'd59, 5'd2,  1'b1};
        vecs[14] = '{3'b001, 30,  3'd0, 6'd3,  6'd59, 5'd2,  1'b1};
        vecs[15] = '{3'b010, 30,  3'd0, 6'd3,  6'd59, 5'd2,  1'b0};

        // Clock/reset
        rst = 1'b1;
        set_btns(3'b000);
        repeat (3) @(negedge msecclk);
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (5) @(negedge msecclk);

        // Table
        for (int i = 0; i < 16; i++) begin
            press(vecs[i].btns, vecs[i].hold);
            check_all($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sec, vecs[i].min,
                      vecs[i].hour, vecs[i].en);
        end

        // Bounce on btn_mode, then steady: one advance, 2 sync + 20 debounce + 1 update.
        for (int i = 0; i < 5; i++) begin
            bus.btn_mode = i[0];
            repeat (3) @(negedge msecclk);
        end
        check("bounce.quiet", 32'(bus.alarm_mode), 0);
        bus.btn_mode = 1'b1;
        lat = 0;
        while (bus.alarm_mode == 3'd0 && lat < 100) begin
            @(negedge msecclk);
            lat++;
        end
        check("bounce.latency", lat, 23);
        repeat (100) @(negedge msecclk);
        bus.btn_mode = 1'b0;
        repeat (40) @(negedge msecclk);
        check("bounce.mode", 32'(bus.alarm_mode), 1);
        check("bounce.en", 32'(bus.alarm_en), 1);

        // Mode and up together: only the mode advance happens.
        press(3'b011, 30);
        check("modeup.mode", 32'(bus.alarm_mode), 2);
        check("modeup.sec", 32'(bus.alarm_sec), 3);

        // Auto-repeat timing: min 59 -> 0, then a 1000 ms hold.
        press(3'b010, 30);
        check("min.wrap", 32'(bus.alarm_min), 0);
        exp_q.push_back(32'd23);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(523 + 100 * k));
        prev = bus.alarm_min;
        bus.btn_up = 1'b1;
        for (t = 1; t <= 1040; t++) begin
            if (t == 1001) bus.btn_up = 1'b0;
            @(negedge msecclk);
            if (bus.alarm_min != prev) begin
                prev = bus.alarm_min;
                if (exp_q.size() == 0) check("repeat.extra", t, 0);
                else                   check("repeat.time", t, exp_q.pop_front());
            end
        end
        check("repeat.missing", exp_q.size(), 0);
        check("repeat.min", 32'(bus.alarm_min), 6);

        // Up and down in the same cycle: ignored.
        press(3'b110, 30);
        check_all("updown", 2, 3, 6, 2, 1);

        // Timeout: SET_HOUR entered 23 cycles after the raw press, idle exit 10000 later.
        press(3'b001, 30);
        check("to.enter", 32'(bus.alarm_mode), 3);
        wait_normal("to.cycles", 9953);
        check_all("to.kept", 0, 3, 6, 2, 1);

        // Pulse in the last idle cycle restarts the timeout.
        press(3'b001, 30);
        press(3'b001, 30);
        press(3'b001, 30);
        check("rs.enter", 32'(bus.alarm_mode), 3);
        repeat (9930) @(negedge msecclk);
        press(3'b100, 30);
        check("rs.mode", 32'(bus.alarm_mode), 3);
        check("rs.hour", 32'(bus.alarm_hour), 1);
        wait_normal("rs.cycles", 9953);

        // Asynchronous reset mid-repeat, button held through reset release.
        press(3'b001, 30);
        press(3'b001, 30);
        bus.btn_up = 1'b1;
        repeat (3500) @(negedge msecclk);
        check("pre_rst.mode", 32'(bus.alarm_mode), 2);
        check("pre_rst.min", 32'(bus.alarm_min), 37);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge msecclk);
        rst = 1'b0;
        repeat (300) @(negedge msecclk);
        bus.btn_up = 1'b0;
        repeat (40) @(negedge msecclk);
        check_all("held_rst", 0, 0, 0, 0, 1);

        // Random presses against the model.
        m_mode = 0; m_sec = 0; m_min = 0; m_hour = 0; m_en = 1;
        for (int r = 0; r < 50; r++) begin
            b = $urandom_range(0, 2);
            h = $urandom_range(30, 700);
            if (h % 100 >= 97 || h % 100 <= 2) h += 10;
            npulse = 1;
            if (b != 0 && h > 500) npulse += (h - 500 + 99) / 100;
            for (int p = 0; p < npulse; p++) model_pulse(b);
            press(3'b001 << b, h);
            check_all($sformatf("rand%0d", r), m_mode, m_sec, m_min, m_hour, m_en);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
